matmul_fifo_ctrl: RTL

- Sequencer for the operand FIFO bank of the systolic matrix multiplier: MAX_DIM A-operand row FIFOs and MAX_DIM B-operand column FIFOs.
- Converts bus-side operand writes into one-hot FIFO write-enable pulses during load.
- On a go command, optionally restores saved operands (reassign), drives the shared start strobe for a fixed run length, then signals completion.
- Sits between the APB register file and the FIFO/PE array.

---
 rtl/matmul_fifo_ctrl_if.sv | 25 ++
 rtl/matmul_fifo_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/matmul_fifo_ctrl_if.sv
// Operand write channel from the register file into the FIFO sequencer.
// The master drives the write request and the slave returns cfg_ready.
interface matmul_fifo_ctrl_if #(
  parameter int BUS_WIDTH = 32,
  parameter int MAX_DIM   = 4
);
  localparam int LW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_sel;
  logic [LW-1:0]        cfg_line;
  logic [LW-1:0]        cfg_place;
  logic [BUS_WIDTH-1:0] cfg_data;

  modport master (
    output cfg_valid, cfg_sel, cfg_line, cfg_place, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_line, cfg_place, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/matmul_fifo_ctrl.sv
// Operand FIFO bank sequencer: one-hot load writes, optional reassign, timed start strobe.
// Optional MATMUL_CTRL_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module matmul_fifo_ctrl #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIM    = 4,
  parameter int RUN_LEN    = 3*MAX_DIM-1,
  localparam int LW        = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  matmul_fifo_ctrl_if.slave    cfg,
  input  logic                 go,
  input  logic                 reuse_a,
  input  logic                 reuse_b,
  output logic [MAX_DIM-1:0]   fifo_a_we,
  output logic [MAX_DIM-1:0]   fifo_b_we,
  output logic [BUS_WIDTH-1:0] fifo_wdata,
  output logic [LW-1:0]        fifo_place,
  output logic                 fifo_start,
  output logic                 fifo_reassign,
  output logic                 fifo_reassign_en_a,
  output logic                 fifo_reassign_en_b,
  output logic                 busy,
`ifdef MATMUL_CTRL_PERF_EN
  output logic [15:0]          perf_cycles,
`endif
  output logic                 done
);

  localparam int CW = $clog2(RUN_LEN+1);

  if (RUN_LEN < 2*MAX_DIM || DATA_WIDTH < 1) begin : g_bad_run_len
    $fatal(1, "matmul_fifo_ctrl: RUN_LEN must be at least 2*MAX_DIM");
  end

  typedef enum logic [1:0] {IDLE, REASSIGN, RUN, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        run_cnt;
  logic                 handshake;
  logic                 we_pending;
  logic                 go_accept;
  logic [MAX_DIM-1:0]   line_onehot;

  assign cfg.cfg_ready = (state == IDLE) && !go;
  assign handshake     = cfg.cfg_valid && cfg.cfg_ready;
  assign we_pending    = (|fifo_a_we) || (|fifo_b_we);
  // Holding off go while a write pulse is in flight guarantees the write lands before start.
  assign go_accept     = (state == IDLE) && go && !we_pending;
  assign line_onehot   = MAX_DIM'(1) << cfg.cfg_line;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      run_cnt            <= '0;
      fifo_a_we          <= '0;
      fifo_b_we          <= '0;
      fifo_wdata         <= '0;
      fifo_place         <= '0;
      fifo_start         <= 1'b0;
      fifo_reassign      <= 1'b0;
      fifo_reassign_en_a <= 1'b0;
      fifo_reassign_en_b <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      fifo_a_we <= '0;
      fifo_b_we <= '0;
      if (handshake) begin
        if (cfg.cfg_sel) fifo_b_we <= line_onehot;
        else             fifo_a_we <= line_onehot;
        fifo_wdata <= cfg.cfg_data;
        fifo_place <= cfg.cfg_place;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go_accept) begin
            busy    <= 1'b1;
            run_cnt <= '0;
            if (reuse_a || reuse_b) begin
              state              <= REASSIGN;
              fifo_reassign      <= 1'b1;
              fifo_reassign_en_a <= reuse_a;
              fifo_reassign_en_b <= reuse_b;
            end else begin
              state      <= RUN;
              fifo_start <= 1'b1;
            end
          end
        end
        REASSIGN: begin
          state              <= RUN;
          fifo_reassign      <= 1'b0;
          fifo_reassign_en_a <= 1'b0;
          fifo_reassign_en_b <= 1'b0;
          fifo_start         <= 1'b1;
        end
        RUN: begin
          if (run_cnt == CW'(RUN_LEN-1)) begin
            state      <= DONE;
            fifo_start <= 1'b0;
            done       <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATMUL_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
    end else if (go_accept) begin
      perf_cycles <= '0;
    end else if (state != IDLE && perf_cycles != 16'hFFFF) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule
